// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Data-side memory bus between the multicycle MIPS core (master) and the
//   memory/I-O responder (slave). The master raises memreq with memwrite, adr
//   and writedata; the slave answers with a one-cycle memready strobe carrying
//   readdata and addrerr.
//
//   memreq     master->slave  access request
//   memwrite   master->slave  1 = store, 0 = load
//   adr        master->slave  byte address
//   writedata  master->slave  store data
//   readdata   slave->master  load result (registered)
//   memready   slave->master  one-cycle response strobe
//   addrerr    slave->master  error flag, valid while memready=1
// -----------------------------------------------------------------------------
interface mem_responder_if;
  logic        memreq;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        memready;
  logic        addrerr;

  modport master (
    output memreq, memwrite, adr, writedata,
    input  readdata, memready, addrerr
  );

  modport slave (
    input  memreq, memwrite, adr, writedata,
    output readdata, memready, addrerr
  );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Bus responder for the core's data-side loads/stores. Serves word accesses
//   to an internal data RAM and a small I/O register block (LED, SEG, SW, BTN,
//   CYCLE), inserting WAIT wait states before a one-cycle memready response.
//
//   Parameters
//     RAM_WORDS  data RAM depth in 32-bit words (power of two, 16..1024)
//     WAIT       wait states before the response (0..15)
//     IO_BASE    byte address of the I/O register block
//
//   Ports
//     clk     system clock, rising edge
//     reset   asynchronous, active-high reset
//     bus     slave side of mem_responder_if
//     sw      board switches (read directly)
//     btn     board buttons (two-flop synchronised before use)
//     led     LED register
//     segval  seven-segment value register
//
//   I/O map (offsets from IO_BASE): 0x00 LED rw, 0x04 SEG rw, 0x08 SW ro,
//   0x0C BTN ro, 0x10 CYCLE ro. Misaligned or unmapped accesses answer with
//   addrerr=1 and readdata=0 and change nothing; stores to RO registers are
//   dropped without error.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int          RAM_WORDS = 64,
  parameter int          WAIT      = 2,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  input  logic [7:0]       sw,
  input  logic [3:0]       btn,
  output logic [7:0]       led,
  output logic [15:0]      segval
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [3:0]  WAIT_LAST = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  localparam logic [2:0]  SEL_LED   = 3'd0;
  localparam logic [2:0]  SEL_SEG   = 3'd1;
  localparam logic [2:0]  SEL_SW    = 3'd2;
  localparam logic [2:0]  SEL_BTN   = 3'd3;
  localparam logic [2:0]  SEL_CYCLE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        capture;
  logic        enter_resp;

  // Captured request
  logic        req_write;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;

  // Operands of the access performed on the edge entering RESP
  logic        acc_write;
  logic [31:0] acc_adr;
  logic [31:0] acc_wdata;

  // Decode
  logic          aligned;
  logic          ram_hit;
  logic          io_hit;
  logic [31:0]   io_off;
  logic [2:0]    io_sel;
  logic [AW-1:0] ram_idx;
  logic          acc_err;
  logic [31:0]   rd_val;

  // Registers
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] readdata_q;
  logic        addrerr_q;
  logic [31:0] cycle_cnt;
  logic [3:0]  btn_meta;
  logic [3:0]  btn_sync;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the
  // case statement, otherwise an unassigned path infers a latch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.memreq) begin
          capture       = 1'b1;
          wait_cnt_next = '0;
          state_next    = (WAIT == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_next    = ST_RESP;
        else                       wait_cnt_next = wait_cnt + 4'd1;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // RESP always lasts one cycle, so entering it is simply next==RESP.
  assign enter_resp = (state_next == ST_RESP);

  // With WAIT=0 the access happens on the capture edge itself, so the live
  // bus values are used while still in IDLE; otherwise the captured copy.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_write = bus.memwrite;
      acc_adr   = bus.adr;
      acc_wdata = bus.writedata;
    end else begin
      acc_write = req_write;
      acc_adr   = req_adr;
      acc_wdata = req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode and read mux
  // ---------------------------------------------------------------------------
  assign aligned = (acc_adr[1:0] == 2'b00);
  assign ram_hit = aligned && (acc_adr[31:AW+2] == '0);
  assign io_off  = acc_adr - IO_BASE;
  assign io_hit  = aligned && !ram_hit && (acc_adr >= IO_BASE) && (io_off < 32'h14);
  assign io_sel  = io_off[4:2];
  assign ram_idx = acc_adr[AW+1:2];
  assign acc_err = !(ram_hit || io_hit);

  always_comb begin
    rd_val = '0;
    if (!acc_err && !acc_write) begin
      if (ram_hit) begin
        rd_val = ram[ram_idx];
      end else begin
        unique case (io_sel)
          SEL_LED:   rd_val = {24'b0, led};
          SEL_SEG:   rd_val = {16'b0, segval};
          SEL_SW:    rd_val = {24'b0, sw};
          SEL_BTN:   rd_val = {28'b0, btn_sync};
          SEL_CYCLE: rd_val = cycle_cnt;
          default:   rd_val = '0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, capture and response registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      req_write  <= 1'b0;
      req_adr    <= '0;
      req_wdata  <= '0;
      readdata_q <= '0;
      addrerr_q  <= 1'b0;
      led        <= '0;
      segval     <= '0;
      cycle_cnt  <= '0;
      btn_meta   <= '0;
      btn_sync   <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      cycle_cnt <= cycle_cnt + 32'd1;
      btn_meta  <= btn;
      btn_sync  <= btn_meta;

      if (capture) begin
        req_write <= bus.memwrite;
        req_adr   <= bus.adr;
        req_wdata <= bus.writedata;
      end

      // addrerr is only high during RESP; readdata holds until the next RESP.
      addrerr_q <= enter_resp && acc_err;
      if (enter_resp) begin
        readdata_q <= rd_val;
        if (acc_write && io_hit) begin
          if (io_sel == SEL_LED) led    <= acc_wdata[7:0];
          if (io_sel == SEL_SEG) segval <= acc_wdata[15:0];
        end
      end
    end
  end

  // NOTE: the RAM array has no reset so it maps onto memory primitives; its
  // contents survive a reset.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && ram_hit) ram[ram_idx] <= acc_wdata;
  end

  assign bus.readdata = readdata_q;
  assign bus.addrerr  = addrerr_q;
  assign bus.memready = (state == ST_RESP);

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. Main instance uses WAIT=2; a second
//   instance with WAIT=0 covers the zero-wait path and continuous requests.
//   Expected data comes from a word-level model of the RAM and I/O registers.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int          RAM_WORDS = 64;
  localparam int          TB_WAIT   = 2;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sw = 8'h00;
  logic [3:0]  btn = 4'h0;
  logic [7:0]  led, led0;
  logic [15:0] segval, segval0;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  always #5 clk = ~clk;

  mem_responder #(.RAM_WORDS(RAM_WORDS), .WAIT(TB_WAIT), .IO_BASE(IO_BASE)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .sw(sw), .btn(btn),
    .led(led), .segval(segval)
  );

  mem_responder #(.RAM_WORDS(RAM_WORDS), .WAIT(0), .IO_BASE(IO_BASE)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .sw(sw), .btn(btn),
    .led(led0), .segval(segval0)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: word-addressed RAM with a written flag, plus LED/SEG.
  logic [31:0] ram_m [RAM_WORDS];
  bit          ram_v [RAM_WORDS];
  logic [7:0]  led_m = 8'h00;
  logic [15:0] seg_m = 16'h0000;

  function automatic void model_step(input bit wr, input logic [31:0] a,
                                     input logic [31:0] wd,
                                     output logic [31:0] rd, output bit err,
                                     output bit known);
    logic [31:0] off;
    int          idx;
    rd = '0; err = 1'b0; known = 1'b1;
    off = a - IO_BASE;
    if (a % 4 != 0) begin
      err = 1'b1;
    end else if (a < RAM_WORDS * 4) begin
      idx = int'(a / 4);
      if (wr) begin
        ram_m[idx] = wd;
        ram_v[idx] = 1'b1;
      end else if (ram_v[idx]) begin
        rd = ram_m[idx];
      end else begin
        known = 1'b0;
      end
    end else if (a >= IO_BASE && off < 32'd20) begin
      case (off)
        32'h00: if (wr) led_m = wd[7:0];   else rd = {24'b0, led_m};
        32'h04: if (wr) seg_m = wd[15:0];  else rd = {16'b0, seg_m};
        32'h08: if (!wr) rd = {24'b0, sw};
        32'h0C: if (!wr) rd = {28'b0, btn};
        default: if (!wr) known = 1'b0;   // CYCLE: checked by differences
      endcase
    end else begin
      err = 1'b1;
    end
  endfunction

  // One access on the WAIT=2 instance. Called at a negedge; returns at a
  // negedge in IDLE. Checks response latency and single-cycle strobe.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err);
    int k;
    bit seen;
    bus.memreq = 1'b1; bus.memwrite = wr; bus.adr = a; bus.writedata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.memreq = 1'b0; bus.memwrite = ~wr; bus.adr = $urandom; bus.writedata = $urandom;
    k = 1; seen = 1'b0;
    while (!seen && k <= 40) begin
      if (bus.memready === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checks++;
    if (!seen || k != TB_WAIT + 1) begin
      failures++;
      $display("FAIL latency adr=%h: got %0d cycles (seen=%0b) expected %0d", a, k, seen, TB_WAIT + 1);
    end
    rd  = bus.readdata;
    err = bus.addrerr;
    @(negedge clk);
    checks++;
    if (bus.memready !== 1'b0 || bus.addrerr !== 1'b0) begin
      failures++;
      $display("FAIL strobe_end adr=%h: got memready=%b addrerr=%b expected 0 0", a, bus.memready, bus.addrerr);
    end
  endtask

  // Same access on the WAIT=0 instance.
  task automatic access0(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
    bus0.memreq = 1'b1; bus0.memwrite = wr; bus0.adr = a; bus0.writedata = wd;
    @(posedge clk);
    @(negedge clk);
    bus0.memreq = 1'b0; bus0.memwrite = ~wr; bus0.adr = $urandom; bus0.writedata = $urandom;
    checks++;
    if (bus0.memready !== 1'b1) begin
      failures++;
      $display("FAIL w0_latency adr=%h: got memready=%b expected 1", a, bus0.memready);
    end
    rd  = bus0.readdata;
    err = bus0.addrerr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.memready, bus.addrerr, bus.readdata, led, segval} !== '0) begin
      failures++;
      $display("FAIL reset_main: got rdy=%b err=%b rd=%h led=%h seg=%h expected all 0",
               bus.memready, bus.addrerr, bus.readdata, led, segval);
    end
    checks++;
    if ({bus0.memready, bus0.addrerr, bus0.readdata, led0, segval0} !== '0) begin
      failures++;
      $display("FAIL reset_w0: got rdy=%b err=%b rd=%h led=%h seg=%h expected all 0",
               bus0.memready, bus0.addrerr, bus0.readdata, led0, segval0);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram();
    logic [31:0] rd, erd;
    logic        err;
    bit          eerr, known;
    model_step(1'b1, 32'h8, 32'hDEADBEEF, erd, eerr, known);
    access(1'b1, 32'h8, 32'hDEADBEEF, rd, err);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL ram_store: got rd=%h err=%b expected 00000000 0", rd, err);
    end
    model_step(1'b0, 32'h8, 32'h0, erd, eerr, known);
    access(1'b0, 32'h8, 32'h0, rd, err);
    checks++;
    if (rd !== erd || err !== 1'b0) begin
      failures++;
      $display("FAIL ram_load: got rd=%h err=%b expected %h 0", rd, err, erd);
    end
  endtask

  task automatic test_io();
    logic [31:0] rd, erd;
    logic        err;
    bit          eerr, known;
    model_step(1'b1, IO_BASE, 32'h1A5, erd, eerr, known);
    access(1'b1, IO_BASE, 32'h1A5, rd, err);
    model_step(1'b1, IO_BASE + 32'h4, 32'h12345678, erd, eerr, known);
    access(1'b1, IO_BASE + 32'h4, 32'h12345678, rd, err);
    checks++;
    if (led !== 8'hA5 || segval !== 16'h5678) begin
      failures++;
      $display("FAIL io_ports: got led=%h seg=%h expected a5 5678", led, segval);
    end
    access(1'b0, IO_BASE, 32'h0, rd, err);
    checks++;
    if (rd !== 32'h000000A5 || err !== 1'b0) begin
      failures++;
      $display("FAIL led_read: got %h err=%b expected 000000a5 0", rd, err);
    end
    access(1'b0, IO_BASE + 32'h4, 32'h0, rd, err);
    checks++;
    if (rd !== 32'h00005678 || err !== 1'b0) begin
      failures++;
      $display("FAIL seg_read: got %h err=%b expected 00005678 0", rd, err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        err;
    access(1'b0, 32'h6, 32'h0, rd, err);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      failures++;
      $display("FAIL misaligned: got rd=%h err=%b expected 00000000 1", rd, err);
    end
    access(1'b0, 32'h4000, 32'h0, rd, err);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      failures++;
      $display("FAIL unmapped: got rd=%h err=%b expected 00000000 1", rd, err);
    end
    access(1'b1, IO_BASE + 32'h8, 32'hFFFF_FFFF, rd, err);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0 || led !== led_m || segval !== seg_m) begin
      failures++;
      $display("FAIL ro_store: got rd=%h err=%b led=%h seg=%h expected 00000000 0 %h %h",
               rd, err, led, segval, led_m, seg_m);
    end
  endtask

  task automatic test_sw_btn_cycle();
    logic [31:0] rd, c1, c2;
    logic        err;
    sw = 8'h3C; btn = 4'b1010;
    repeat (3) @(negedge clk);
    access(1'b0, IO_BASE + 32'h8, 32'h0, rd, err);
    checks++;
    if (rd !== 32'h0000003C || err !== 1'b0) begin
      failures++;
      $display("FAIL sw_read: got %h err=%b expected 0000003c 0", rd, err);
    end
    access(1'b0, IO_BASE + 32'hC, 32'h0, rd, err);
    checks++;
    if (rd !== 32'h0000000A || err !== 1'b0) begin
      failures++;
      $display("FAIL btn_read: got %h err=%b expected 0000000a 0", rd, err);
    end
    access(1'b0, IO_BASE + 32'h10, 32'h0, c1, err);
    access(1'b0, IO_BASE + 32'h10, 32'h0, c2, err);
    checks++;
    if (c2 - c1 !== 32'(TB_WAIT + 2)) begin
      failures++;
      $display("FAIL cycle_delta: got %0d expected %0d", c2 - c1, TB_WAIT + 2);
    end
  endtask

  task automatic test_wait0();
    logic [31:0] rd;
    logic        err;
    access0(1'b1, 32'hC, 32'h11223344, rd, err);
    access0(1'b0, 32'hC, 32'h0, rd, err);
    checks++;
    if (rd !== 32'h11223344 || err !== 1'b0) begin
      failures++;
      $display("FAIL w0_load: got rd=%h err=%b expected 11223344 0", rd, err);
    end
    // Request held high: response every second cycle, never adjacent.
    bus0.memreq = 1'b1; bus0.memwrite = 1'b0; bus0.adr = 32'hC;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (bus0.memready !== 1'(k % 2)) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got memready=%b expected %0d", k, bus0.memready, k % 2);
      end
    end
    bus0.memreq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_during_wait();
    logic [31:0] rd, erd;
    logic        err;
    bit          eerr, known;
    model_step(1'b1, 32'h14, 32'hCAFE0005, erd, eerr, known);
    access(1'b1, 32'h14, 32'hCAFE0005, rd, err);
    bus.memreq = 1'b1; bus.memwrite = 1'b1; bus.adr = 32'h14; bus.writedata = 32'h0BAD0BAD;
    @(posedge clk);
    @(negedge clk);
    bus.memreq = 1'b0;
    reset = 1'b1;
    led_m = 8'h00; seg_m = 16'h0000;
    @(negedge clk);
    checks++;
    if ({bus.memready, bus.addrerr, bus.readdata, led, segval} !== '0) begin
      failures++;
      $display("FAIL reset_abort: got rdy=%b err=%b rd=%h led=%h seg=%h expected all 0",
               bus.memready, bus.addrerr, bus.readdata, led, segval);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.memready !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_ready cycle %0d: got memready=%b expected 0", k, bus.memready);
      end
    end
    model_step(1'b0, 32'h14, 32'h0, erd, eerr, known);
    access(1'b0, 32'h14, 32'h0, rd, err);
    checks++;
    if (rd !== erd || err !== 1'b0) begin
      failures++;
      $display("FAIL ram_after_reset: got rd=%h err=%b expected %h 0", rd, err, erd);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, erd;
    logic        err;
    bit          wr, eerr, known;
    sw = 8'($urandom); btn = 4'($urandom);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 5))
        0, 1: a = 32'($urandom_range(0, RAM_WORDS - 1)) * 4;
        2:    a = IO_BASE + 32'($urandom_range(0, 4)) * 4;
        3:    a = 32'($urandom_range(0, RAM_WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
        4:    a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        default: a = IO_BASE + 32'h14 + 32'($urandom_range(0, 58)) * 4;
      endcase
      model_step(wr, a, wd, erd, eerr, known);
      access(wr, a, wd, rd, err);
      checks++;
      if (err !== eerr || (known && rd !== erd)) begin
        failures++;
        $display("FAIL random[%0d] wr=%0b adr=%h: got rd=%h err=%b expected rd=%h err=%b",
                 i, wr, a, rd, err, erd, eerr);
      end
      checks++;
      if (led !== led_m || segval !== seg_m) begin
        failures++;
        $display("FAIL random_regs[%0d]: got led=%h seg=%h expected %h %h", i, led, segval, led_m, seg_m);
      end
    end
  endtask

  initial begin
    bus.memreq = 1'b0;  bus.memwrite = 1'b0;  bus.adr = '0;  bus.writedata = '0;
    bus0.memreq = 1'b0; bus0.memwrite = 1'b0; bus0.adr = '0; bus0.writedata = '0;
    test_reset();
    test_ram();
    test_io();
    test_errors();
    test_sw_btn_cycle();
    test_wait0();
    test_reset_during_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
